dither_lfsr_multi: RTL

- Parametrised pseudo-random dither generator for the NCO phase-truncation path.
- Successor to the fixed 8-bit / 3-bit dither block.
- Runs two independent Fibonacci LFSRs of selectable width. Produces OUT_W-bit dither in rectangular (RPDF) or triangular (TPDF) mode.
- Adds runtime reseed, a warm-up discard phase, and valid/busy status.

---
 rtl/dither_lfsr_multi.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dither_lfsr_multi.sv
// rtl/dither_lfsr_multi.sv - dual Fibonacci LFSR dither generator with RPDF/TPDF output, reseed and warm-up
module dither_lfsr_multi #(
  parameter int                LFSR_W = 8,
  parameter int                OUT_W  = 3,
  parameter logic [LFSR_W-1:0] SEED_A = LFSR_W'(8'hAA),
  parameter logic [LFSR_W-1:0] SEED_B = LFSR_W'(8'h55),
  parameter int                WARMUP = 16
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              inCS,
  input  logic [1:0]        imode,
  input  logic              iseed_load,
  input  logic [LFSR_W-1:0] iseed,
  output logic [OUT_W-1:0]  out,
  output logic              ovalid,
  output logic              obusy
);

  // Only the four tabulated lengths have known maximal-length tap sets.
  generate
    if (!(LFSR_W == 8 || LFSR_W == 16 || LFSR_W == 24 || LFSR_W == 32)) begin : g_bad_lfsr_w
      $error("dither_lfsr_multi: LFSR_W must be 8, 16, 24 or 32");
    end
    if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
      $error("dither_lfsr_multi: OUT_W must be in 1..LFSR_W");
    end
    if (SEED_A == {LFSR_W{1'b1}} || SEED_B == {LFSR_W{1'b1}}) begin : g_bad_seed
      $error("dither_lfsr_multi: seeds must not be the all-ones lockup state");
    end
  endgenerate

  // Tap masks (bit n-1 for 1-indexed tap n); XNOR feedback makes all-ones the lockup state.
  localparam logic [LFSR_W-1:0] TAPS =
    (LFSR_W == 8)  ? LFSR_W'(32'h0000_00B8) :
    (LFSR_W == 16) ? LFSR_W'(32'h0000_D008) :
    (LFSR_W == 24) ? LFSR_W'(32'h00E1_0000) :
                     LFSR_W'(32'h8020_0003);

  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Where reset and reseed land: warm-up only exists when WARMUP is non-zero.
  localparam state_t ST_INIT = (WARMUP > 0) ? ST_WARM : ST_RUN;

  logic [LFSR_W-1:0] a_q, a_d;
  logic [LFSR_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              ovalid_q, ovalid_d;
  logic              obusy_q, obusy_d;

  logic [OUT_W-1:0]  top_a, top_b;
  logic [OUT_W:0]    tri_sum;
  logic [LFSR_W-1:0] seed_b_mix;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ~(^(v & TAPS))};
  endfunction

  // Next-state: reseed beats stepping; warm-up steps are discarded, run steps produce a word.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    out_d      = out_q;
    ovalid_d   = 1'b0;
    top_a      = a_q[LFSR_W-1 -: OUT_W];
    top_b      = b_q[LFSR_W-1 -: OUT_W];
    tri_sum    = {1'b0, top_a} + {1'b0, top_b};
    seed_b_mix = iseed ^ SEED_B;

    if (iseed_load) begin
      a_d     = (&iseed) ? SEED_A : iseed;
      b_d     = (&seed_b_mix) ? SEED_B : seed_b_mix;
      cnt_d   = '0;
      state_d = ST_INIT;
    end else if (!inCS) begin
      a_d = lfsr_next(a_q);
      b_d = lfsr_next(b_q);
      if (state_q == ST_WARM) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end else begin
        case (imode)
          2'b01:   out_d = top_a;
          2'b10:   out_d = tri_sum[OUT_W:1];
          default: out_d = '0;
        endcase
        ovalid_d = 1'b1;
      end
    end

    obusy_d = (state_d == ST_WARM);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      a_q      <= SEED_A;
      b_q      <= SEED_B;
      cnt_q    <= '0;
      state_q  <= ST_INIT;
      out_q    <= '0;
      ovalid_q <= 1'b0;
      obusy_q  <= (ST_INIT == ST_WARM);
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      out_q    <= out_d;
      ovalid_q <= ovalid_d;
      obusy_q  <= obusy_d;
    end
  end

  assign out    = out_q;
  assign ovalid = ovalid_q;
  assign obusy  = obusy_q;

endmodule
